// File: rtl/hpmcounter_bank.sv
// Bank of RISC-V mhpmcounter3+/mhpmevent3+ counters with per-counter event select,
// privilege-mode inhibit, Sscofpmf-style overflow flag and local counter-overflow interrupt.
module hpmcounter_bank #(
  parameter int XLEN         = 64,
  parameter int NUM_COUNTERS = 4,
  parameter int NUM_EVENTS   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_EVENTS-1:0] EventsM,
  input  logic [1:0]            PrivilegeModeW,
  input  logic                  CSRWriteM,
  input  logic [11:0]           CSRAdrM,
  input  logic [XLEN-1:0]       CSRWriteValM,
  output logic [XLEN-1:0]       CSRReadValM,
  output logic                  CSRHitM,
  output logic                  LCOFIntM
);

  logic [63:0]             count [NUM_COUNTERS];
  logic [7:0]              evsel [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] minh, sinh, uinh, of, cntinh;
  logic [NUM_EVENTS-1:0]   events_r;
  logic [1:0]              mode_r;

  logic                    sel_cnt, sel_cnth, sel_evt, sel_evth, sel_inh;
  logic [4:0]              idx;
  logic [NUM_COUNTERS-1:0] ev_hit, mode_inh, inc;
  logic [63:0]             rdata;

  // Index fields 3..31 of each 32-entry CSR block map onto counters 0..28.
  always_comb begin
    idx      = CSRAdrM[4:0] - 5'd3;
    sel_inh  = (CSRAdrM == 12'h320);
    sel_cnt  = (CSRAdrM[11:5] == 7'h58) && (CSRAdrM[4:0] >= 5'd3);
    sel_evt  = (CSRAdrM[11:5] == 7'h19) && (CSRAdrM[4:0] >= 5'd3);
    sel_cnth = (XLEN == 32) && (CSRAdrM[11:5] == 7'h5C) && (CSRAdrM[4:0] >= 5'd3);
    sel_evth = (XLEN == 32) && (CSRAdrM[11:5] == 7'h39) && (CSRAdrM[4:0] >= 5'd3);
    CSRHitM  = sel_inh | sel_cnt | sel_evt | sel_cnth | sel_evth;
  end

  always_comb begin
    ev_hit   = '0;
    mode_inh = '0;
    for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
      for (int unsigned k = 0; k < NUM_EVENTS; k++) begin
        if ((evsel[i] == 8'(k + 1)) && events_r[k]) ev_hit[i] = 1'b1;
      end
      case (mode_r)
        2'd3:    mode_inh[i] = minh[i];
        2'd1:    mode_inh[i] = sinh[i];
        2'd0:    mode_inh[i] = uinh[i];
        default: mode_inh[i] = 1'b0;
      endcase
    end
    inc = ev_hit & ~cntinh & ~mode_inh;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      events_r <= '0;
      mode_r   <= '0;
      cntinh   <= '0;
      minh     <= '0;
      sinh     <= '0;
      uinh     <= '0;
      of       <= '0;
      for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
        count[i] <= '0;
        evsel[i] <= '0;
      end
    end else begin
      events_r <= EventsM;
      mode_r   <= PrivilegeModeW;
      if (CSRWriteM && sel_inh) cntinh <= CSRWriteValM[3 +: NUM_COUNTERS];
      for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
        // A counter write suppresses that cycle's increment and overflow.
        if (CSRWriteM && sel_cnt && (idx == 5'(i))) begin
          if (XLEN == 64) count[i] <= 64'(CSRWriteValM);
          else            count[i][31:0] <= CSRWriteValM[31:0];
        end else if (CSRWriteM && sel_cnth && (idx == 5'(i))) begin
          count[i][63:32] <= CSRWriteValM[31:0];
        end else if (inc[i]) begin
          count[i] <= count[i] + 64'd1;
          if (&count[i]) of[i] <= 1'b1;
        end
        // Flag writes come after the overflow set so the written OF wins.
        if (CSRWriteM && sel_evt && (idx == 5'(i))) begin
          evsel[i] <= CSRWriteValM[7:0];
          if (XLEN == 64) {of[i], minh[i], sinh[i], uinh[i]} <= CSRWriteValM[XLEN-1 -: 4];
        end
        if (CSRWriteM && sel_evth && (idx == 5'(i)))
          {of[i], minh[i], sinh[i], uinh[i]} <= CSRWriteValM[XLEN-1 -: 4];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (sel_inh) rdata = 64'({cntinh, 3'b000});
    for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
      if (idx == 5'(i)) begin
        if (sel_cnt)  rdata = (XLEN == 64) ? count[i] : {32'b0, count[i][31:0]};
        if (sel_cnth) rdata = {32'b0, count[i][63:32]};
        if (sel_evt)  rdata = (XLEN == 64) ? {of[i], minh[i], sinh[i], uinh[i], 52'b0, evsel[i]}
                                           : {56'b0, evsel[i]};
        if (sel_evth) rdata = {32'b0, of[i], minh[i], sinh[i], uinh[i], 28'b0};
      end
    end
    CSRReadValM = rdata[XLEN-1:0];
  end

  assign LCOFIntM = |of;

endmodule

// File: doc/hpmcounter_bank.md
# hpmcounter_bank

Parametrised bank of RISC-V machine hardware performance-monitor counters (mhpmcounter3+ / mhpmevent3+) with per-counter event select, privilege-mode inhibit and Sscofpmf-style overflow flag with local counter-overflow interrupt. It sits beside the CSR unit in the privileged unit: it consumes per-cycle event pulses from the pipeline and caches, and the CSR unit routes HPM-range CSR reads and writes to it. It is generalised over XLEN, counter count and event count, and adds mode-filtered counting, overflow detection and an interrupt output.

## Interface
Parameters:
- XLEN, 64, 32 or 64; selects whether the high-half CSRs exist.
- NUM_COUNTERS, 4, implemented counters (1..29), counter i maps to hpm index 3+i.
- NUM_EVENTS, 16, width of event vector (1..255).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- EventsM  in  NUM_EVENTS  per-cycle event pulses, any number may be high.
- PrivilegeModeW  in  2  current privilege mode (0 U, 1 S, 3 M).
- CSRWriteM  in  1  qualified CSR write strobe (already excludes flushed and stalled instructions).
- CSRAdrM  in  12  CSR address.
- CSRWriteValM  in  XLEN  write data.
- CSRReadValM  out  XLEN  combinational read data for CSRAdrM.
- CSRHitM  out  1  CSRAdrM falls in this block's address map.
- LCOFIntM  out  1  local counter-overflow interrupt request (mip bit 13 source).

## Operation
- Address map for i in 0..28: mhpmcounter 0xB03+i, mhpmevent 0x323+i, mcountinhibit 0x320. For XLEN=32 only: mhpmcounterh 0xB83+i, mhpmeventh 0x723+i.
- CSRHitM is high for every address in the map, including indices at or above NUM_COUNTERS. Unimplemented indices read 0 and ignore writes.
- State per counter: 64-bit count, 8-bit evsel, MINH, SINH, UINH, OF. The block also holds mcountinhibit bits [3+NUM_COUNTERS-1:3]. mcountinhibit bits 0..2 and bits above the implemented counters read 0.
- mhpmevent read layout:
  - XLEN=64: {OF, MINH, SINH, UINH, 52'b0, evsel}.
  - XLEN=32: low word {24'b0, evsel}; mhpmeventh {OF, MINH, SINH, UINH, 28'b0}.
- Writes to OF, MINH, SINH, UINH and evsel store exactly the written bit values.
- Event select: evsel=k with 1≤k≤NUM_EVENTS counts EventsM[k-1]. evsel=0, or evsel>NUM_EVENTS, never counts.
- Increment condition: the registered event bit is high, mcountinhibit[3+i]=0, and the mode-inhibit bit for the registered mode is 0. The mode-inhibit bit is MINH for M, SINH for S, UINH for U; mode 2 is never inhibited.
- Arithmetic: modulo 2^64 increment by 1.
- Overflow: an increment from all-ones to 0 sets OF. If OF is already 1 it stays 1.
- LCOFIntM = OR of all OF bits, level-sensitive. It is cleared only by software writing OF=0.
- Write/increment collision: a write to any half of counter i in the same cycle as its increment wins, and the increment (and any OF set) is dropped. On XLEN=32 the unwritten half keeps its pre-cycle value.
- A write to mhpmevent in the same cycle as an overflow: the written OF value wins.

## Timing
- Event pipeline: EventsM and PrivilegeModeW are registered once into EventsR and ModeR. An event in cycle n updates the counter at the clock edge ending cycle n+1, so it is visible on CSRReadValM in cycle n+2.
- Filtering uses ModeR (the mode at the event cycle), not the current mode.
- CSR writes take effect at the edge ending the write cycle; the new value is readable the next cycle.
- A write to mcountinhibit or mhpmevent affects increments evaluated from the next cycle onward. An event already in EventsR is evaluated with the new settings.
- OF and LCOFIntM rise at the same edge as the wrapping increment.
- Reset (asynchronous assert, synchronous-safe deassert upstream) clears all of the following to 0: counters, evsel, MINH, SINH, UINH, OF, mcountinhibit, EventsR and ModeR. LCOFIntM is therefore 0 and CSRReadValM reads 0 for every address.
- Reset mid-count discards the in-flight EventsR.

## Test plan
- Basic count: NUM_COUNTERS=4; write mhpmevent3 evsel=2; pulse EventsM[1] for 5 cycles in M mode -> mhpmcounter3 reads 5 two cycles after the last pulse; the other counters read 0.
- Mode filter: set SINH on counter 0; pulse the event 3 times in S mode and 2 times in U mode -> count 2. Also set UINH -> further U-mode pulses leave the count at 2.
- Overflow: write mhpmcounter3=0xFFFF_FFFF_FFFF_FFFE; 2 event pulses -> count 0, OF=1, LCOFIntM=1. A third pulse gives count 1, and OF and LCOFIntM stay 1. Writing mhpmevent3 with OF=0 drops LCOFIntM the next cycle.
- Collision: a write of 100 to mhpmcounter4 in the same cycle an increment is due -> reads 100, not 101. On XLEN=32, writing 0xB84 high=7 while low=0xFFFF_FFFF increments -> {7, 0xFFFF_FFFF}.
- Inhibit and unimplemented: setting mcountinhibit bit 3 freezes counter 0 under continuous events. Reading 0xB1F (index 28, unimplemented) gives CSRHitM=1 and a value of 0, and writes there are ignored. evsel=200 with NUM_EVENTS=16 never counts.
- Reset: assert reset_n low mid-count with OF set -> all reads return 0 and LCOFIntM=0 immediately, with no clock edge needed.
